// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator display block.
// States, segment codes (active-low {g,f,e,d,c,b,a}) and the double-dabble adjust helper.
package calc_pkg;

    typedef enum logic [0:0] {IDLE, CONV} state_e;

    localparam int unsigned NUM_DIGITS = 4;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;

    // Add 3 to every BCD nibble >= 5 so the following left shift carries correctly.
    function automatic logic [11:0] bcd_adjust(input logic [11:0] bcd);
        logic [11:0] res;
        res = bcd;
        for (int i = 0; i < 3; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5) begin
                res[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/calc_display_if.sv
// Value handshake and display outputs of calc_display.
// master drives values in and watches the display; slave is the display block.
interface calc_display_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] result;
    logic       zero;
    logic       overflow;
    logic [6:0] seg;
    logic [3:0] an;
    logic       zero_led;
    logic       ovf_led;

    modport master (
        output in_valid, result, zero, overflow,
        input  in_ready, seg, an, zero_led, ovf_led
    );

    modport slave (
        input  in_valid, result, zero, overflow,
        output in_ready, seg, an, zero_led, ovf_led
    );
endinterface

// File: rtl/seg7_decoder.sv
// BCD to active-low seven-segment decoder with a forced-blank input.
// Codes outside 0-9 decode to blank.
module seg7_decoder
    import calc_pkg::*;
(
    input  logic [3:0] code,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            case (code)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/calc_display.sv
// Converts an 8-bit ALU result to BCD (double dabble) and multiplexes it onto a 4-digit display.
// Define LEAD_ZERO_BLANK_EN to blank leading zeros in the hundreds and tens digits.
module calc_display
    import calc_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 50000
) (
    input logic           clk,
    input logic           rst,
    calc_display_if.slave bus
);

    localparam int unsigned DIGIT_W = $clog2(NUM_DIGITS);

`ifdef LEAD_ZERO_BLANK_EN
    localparam logic LZ_BLANK = 1'b1;
`else
    localparam logic LZ_BLANK = 1'b0;
`endif

    state_e state_q, state_d;
    logic   in_ready, xfer, conv_last;

    logic [2:0]  step_q;
    logic [7:0]  shift_q;
    logic [11:0] bcd_q;
    logic [19:0] dd_nxt;
    logic [3:0]  hund_q, tens_q, units_q;
    logic        zero_led_q, ovf_led_q;

    logic [15:0]        refresh_q;
    logic [DIGIT_W-1:0] digit_idx_q;

    logic [3:0] dig_code;
    logic       dig_blank;
    logic [6:0] dec_seg;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid) state_d = CONV;
            CONV:    if (step_q == 3'd7) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        in_ready  = (state_q == IDLE);
        xfer      = in_ready && bus.in_valid;
        conv_last = (state_q == CONV) && (step_q == 3'd7);
    end

    always_comb begin
        dd_nxt = {bcd_adjust(bcd_q), shift_q} << 1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_q     <= '0;
            shift_q    <= '0;
            bcd_q      <= '0;
            hund_q     <= '0;
            tens_q     <= '0;
            units_q    <= '0;
            zero_led_q <= 1'b0;
            ovf_led_q  <= 1'b0;
        end else if (xfer) begin
            step_q     <= '0;
            shift_q    <= bus.result;
            bcd_q      <= '0;
            zero_led_q <= bus.zero;
            ovf_led_q  <= bus.overflow;
        end else if (state_q == CONV) begin
            step_q  <= step_q + 3'd1;
            shift_q <= dd_nxt[7:0];
            bcd_q   <= dd_nxt[19:8];
            // Display only changes once the final shift is complete.
            if (conv_last) begin
                hund_q  <= dd_nxt[19:16];
                tens_q  <= dd_nxt[15:12];
                units_q <= dd_nxt[11:8];
            end
        end
    end

    // Digit scan runs free of the conversion FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refresh_q   <= '0;
            digit_idx_q <= '0;
        end else if (refresh_q == 16'(REFRESH_DIV - 1)) begin
            refresh_q   <= '0;
            digit_idx_q <= digit_idx_q + 1'b1;
        end else begin
            refresh_q <= refresh_q + 16'd1;
        end
    end

    always_comb begin
        dig_code  = 4'd0;
        dig_blank = 1'b1;
        case (digit_idx_q)
            2'd0: begin
                dig_code  = units_q;
                dig_blank = 1'b0;
            end
            2'd1: begin
                dig_code  = tens_q;
                dig_blank = LZ_BLANK && (hund_q == 4'd0) && (tens_q == 4'd0);
            end
            2'd2: begin
                dig_code  = hund_q;
                dig_blank = LZ_BLANK && (hund_q == 4'd0);
            end
            default: begin
                dig_code  = 4'd0;
                dig_blank = 1'b1;
            end
        endcase
    end

    seg7_decoder u_dec (
        .code  (dig_code),
        .blank (dig_blank),
        .seg   (dec_seg)
    );

    always_comb begin
        bus.in_ready = in_ready;
        bus.zero_led = zero_led_q;
        bus.ovf_led  = ovf_led_q;
        bus.an       = ~(4'b0001 << digit_idx_q);
        if (digit_idx_q == 2'd3) begin
            bus.seg = ovf_led_q ? SEG_E : SEG_BLANK;
        end else begin
            bus.seg = dec_seg;
        end
    end

endmodule

// File: tb/tb_calc_display.sv
// Self-checking bench for calc_display: per-cycle compare against a decimal-arithmetic model,
// plus hand-computed literal checks of the directed scenarios.
module tb_calc_display;

    localparam int unsigned DIV = 4;

`ifdef LEAD_ZERO_BLANK_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    bit   started = 1'b0;

    int checks   = 0;
    int failures = 0;

    calc_display_if bus ();

    calc_display #(.REFRESH_DIV(DIV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0:       return 7'b1000000;
            1:       return 7'b1111001;
            2:       return 7'b0100100;
            3:       return 7'b0110000;
            4:       return 7'b0011001;
            5:       return 7'b0010010;
            6:       return 7'b0000010;
            7:       return 7'b1111000;
            8:       return 7'b0000000;
            9:       return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Model: value latched on transfer, shown in decimal 8 clocks later.
    int   m_busy = 0, m_val = 0, m_h = 0, m_t = 0, m_u = 0, m_cyc = 0;
    logic m_z = 1'b0, m_o = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 0;
            m_h    <= 0;
            m_t    <= 0;
            m_u    <= 0;
            m_z    <= 1'b0;
            m_o    <= 1'b0;
            m_cyc  <= 0;
        end else begin
            m_cyc <= m_cyc + 1;
            if (m_busy > 0) begin
                m_busy <= m_busy - 1;
                if (m_busy == 1) begin
                    m_h <= m_val / 100;
                    m_t <= (m_val / 10) % 10;
                    m_u <= m_val % 10;
                end
            end else if (bus.in_valid) begin
                m_val  <= int'(bus.result);
                m_z    <= bus.zero;
                m_o    <= bus.overflow;
                m_busy <= 8;
            end
        end
    end

    function automatic logic [6:0] exp_seg(input int idx);
        case (idx)
            0:       return seg_of(m_u);
            1:       return (LZ && m_h == 0 && m_t == 0) ? 7'b1111111 : seg_of(m_t);
            2:       return (LZ && m_h == 0) ? 7'b1111111 : seg_of(m_h);
            default: return m_o ? 7'b0000110 : 7'b1111111;
        endcase
    endfunction

    always @(negedge clk) begin
        if (started) begin
            int         idx;
            logic [3:0] e_an;
            idx  = (m_cyc / DIV) % 4;
            e_an = ~(4'b0001 << idx);
            check("an", 32'(bus.an), 32'(e_an));
            check("seg", 32'(bus.seg), 32'(exp_seg(idx)));
            check("in_ready", 32'(bus.in_ready), 32'(m_busy == 0));
            check("zero_led", 32'(bus.zero_led), 32'(m_z));
            check("ovf_led", 32'(bus.ovf_led), 32'(m_o));
        end
    end

    // Wait until the given digit is selected, then compare its segments to a literal.
    task automatic digit_is(input string name, input logic [3:0] want_an, input logic [6:0] want);
        int  n;
        bit  found;
        found = 1'b0;
        n = 0;
        while (!found && n < 24) begin
            @(negedge clk);
            if (bus.an == want_an) found = 1'b1;
            n++;
        end
        if (found) begin
            check(name, 32'(bus.seg), 32'(want));
        end else begin
            checks++;
            failures++;
            $display("FAIL %s: digit an=%b never selected", name, want_an);
        end
    endtask

    // One transfer; inputs are scrambled during conversion and must be ignored.
    task automatic send(input logic [7:0] r, input logic z, input logic o, output int low_cycles);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        bus.result   = r;
        bus.zero     = z;
        bus.overflow = o;
        bus.in_valid = 1'b1;
        @(negedge clk);
        n = 0;
        while (!bus.in_ready && n < 20) begin
            n++;
            bus.in_valid = (n < 5);
            bus.result   = r ^ 8'h5a;
            bus.zero     = ~z;
            bus.overflow = ~o;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        low_cycles   = n;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int         low;
        int         last;
        logic [3:0] an_tab [4];
        an_tab = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

        bus.in_valid = 1'b0;
        bus.result   = 8'd0;
        bus.zero     = 1'b0;
        bus.overflow = 1'b0;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        started = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_an", 32'(bus.an), 32'(4'b1110));
        check("rst_ready", 32'(bus.in_ready), 32'd1);
        check("rst_zero_led", 32'(bus.zero_led), 32'd0);
        check("rst_ovf_led", 32'(bus.ovf_led), 32'd0);
        check("rst_units", 32'(bus.seg), 32'(7'b1000000));

        // 200: busy for 8 cycles, then 2,0,0
        send(8'd200, 1'b0, 1'b0, low);
        check("busy_200", 32'(low), 32'd8);
        digit_is("u_200", 4'b1110, 7'b1000000);
        digit_is("t_200", 4'b1101, 7'b1000000);
        digit_is("h_200", 4'b1011, 7'b0100100);
        check("ovf_200", 32'(bus.ovf_led), 32'd0);

        // 7: leading zeros
        send(8'd7, 1'b0, 1'b0, low);
        check("busy_7", 32'(low), 32'd8);
        digit_is("h_7", 4'b1011, LZ ? 7'b1111111 : 7'b1000000);
        digit_is("t_7", 4'b1101, LZ ? 7'b1111111 : 7'b1000000);
        digit_is("u_7", 4'b1110, 7'b1111000);

        // 44 with overflow, then 0 with zero flag
        send(8'd44, 1'b0, 1'b1, low);
        digit_is("flag_44", 4'b0111, 7'b0000110);
        check("ovf_44", 32'(bus.ovf_led), 32'd1);
        digit_is("u_44", 4'b1110, 7'b0011001);
        send(8'd0, 1'b1, 1'b0, low);
        digit_is("flag_0", 4'b0111, 7'b1111111);
        check("zero_0", 32'(bus.zero_led), 32'd1);
        digit_is("u_0", 4'b1110, 7'b1000000);

        // 159 to show a nonzero value, then 255 aborted by reset mid-conversion
        send(8'd159, 1'b0, 1'b0, low);
        digit_is("h_159", 4'b1011, 7'b1111001);
        @(negedge clk);
        bus.result   = 8'd255;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1 check("ready_after_rst", 32'(bus.in_ready), 32'd1);
        check("an_after_rst", 32'(bus.an), 32'(4'b1110));
        check("u_after_rst", 32'(bus.seg), 32'(7'b1000000));

        // Refresh sequence with a conversion in flight: 4 clocks per digit
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            check("scan_an", 32'(bus.an), 32'(an_tab[(k / 4) % 4]));
            bus.in_valid = (k == 2);
            bus.result   = 8'd123;
        end
        bus.in_valid = 1'b0;
        digit_is("h_123", 4'b1011, 7'b1111001);
        digit_is("t_123", 4'b1101, 7'b0100100);
        digit_is("u_123", 4'b1110, 7'b0110000);

        // Streaming: in_valid held high, result changes every cycle
        last = -1;
        for (int i = 0; i < 48; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                if (last >= 0) check("stream_gap", 32'(i - last), 32'd9);
                last = i;
            end
            bus.in_valid = 1'b1;
            bus.result   = 8'(i * 37 + 11);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (40) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/calc_display.md
CALC_DISPLAY -- requirements
Module: calc_display

Interface
REQ-001 Parameter: REFRESH_DIV, default 50000, clocks each display digit stays active; legal range 2..65535.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  the result, zero and overflow inputs carry a new value.
REQ-005 in_ready  output  1  block can accept a value this cycle.
REQ-006 result  input  8  unsigned ALU result to display.
REQ-007 zero  input  1  ALU zero flag.
REQ-008 overflow  input  1  ALU carry/borrow flag.
REQ-009 seg  output  7  active-low segments, bit order {g,f,e,d,c,b,a}.
REQ-010 an  output  4  active-low one-hot digit enables; an[0] is units, an[3] is the flag digit.
REQ-011 zero_led  output  1  latched zero flag.
REQ-012 ovf_led  output  1  latched overflow flag.

Function
REQ-013 Transfer occurs on a rising edge where in_valid=1 and in_ready=1; in_ready SHALL equal (state==IDLE).
REQ-014 State machine: IDLE -> CONV on transfer; CONV -> IDLE after exactly 8 CONV cycles; no other transitions.
REQ-015 On transfer: load result into the shift register, clear the 12-bit BCD accumulator, latch zero and overflow into zero_led and ovf_led.
REQ-016 Each CONV cycle: add 3 to every BCD nibble >= 5, then shift {bcd, shift_reg} left by 1 (double dabble).
REQ-017 On the 8th CONV edge (transfer edge + 8), write the hundreds, tens and units digits to the display registers and return to IDLE. The earliest next transfer is transfer edge + 9.
REQ-018 Display registers and LEDs SHALL hold their value during CONV; the old value stays visible until REQ-017.
REQ-019 Inputs that change while in CONV SHALL be ignored.
REQ-020 Refresh counter counts 0..REFRESH_DIV-1 and wraps. On wrap, the digit index advances 0->1->2->3->0.
REQ-021 an is the active-low one-hot of the digit index. seg shows the selected digit, decoded combinationally from the display registers.
REQ-022 Digit 3 shows 'E' (7'b0000110) when ovf_led=1, and blank (7'b1111111) otherwise.
REQ-023 BCD codes 0-9 use standard encodings ('0'=7'b1000000, '7'=7'b1111000). Non-BCD codes SHALL decode to blank.
REQ-024 Digit refresh is independent of the state machine and never stalls.

Reset
REQ-025 On rst: state=IDLE, in_ready=1, display digits=0,0,0, zero_led=0, ovf_led=0, refresh counter=0, digit index=0, an=4'b1110.
REQ-026 rst during CONV SHALL abort conversion with no display update. in_ready SHALL be 1 on the first edge after release.

Configuration
REQ-027 Macro LEAD_ZERO_BLANK_EN defined: blank the hundreds digit when it is 0; blank the tens digit when hundreds and tens are both 0; never blank the units digit.
REQ-028 Macro LEAD_ZERO_BLANK_EN undefined: all three numeric digits are always shown, including leading zeros.

Structure
REQ-029 Shared package calc_pkg SHALL hold the state enum (IDLE, CONV), the segment constants (SEG_BLANK, SEG_E, digit codes 0-9) and the NUM_DIGITS=4 constant.
REQ-030 Sub-module seg7_decoder: takes a 4-bit code plus a blank input and returns 7-bit active-low segments; exactly one instance, on the selected digit.

Verification
REQ-031 Apply result=200, overflow=0, in_valid for 1 cycle -> in_ready low for 8 cycles; digits become 2,0,0 at transfer edge + 8; ovf_led=0.
REQ-032 With LEAD_ZERO_BLANK_EN, apply result=7 -> hundreds and tens segments = 7'b1111111, units = 7'b1111000. Without the macro -> 7'b1000000, 7'b1000000, 7'b1111000.
REQ-033 Apply result=44, overflow=1 -> digit 3 seg=7'b0000110, ovf_led=1. Then apply result=0, zero=1 -> digit 3 blank, zero_led=1, units shows '0'.
REQ-034 Apply result=255, then assert rst 4 cycles after transfer -> display shows 0,0,0, an=4'b1110, in_ready=1 on the first edge after release.
REQ-035 Hold in_valid high while result varies every cycle -> transfers occur exactly every 9 cycles. Each displayed value equals the result sampled at its transfer edge.
REQ-036 Set REFRESH_DIV=4 -> an sequence 1110, 1101, 1011, 0111, 1110 with each step lasting exactly 4 clocks, unaffected by concurrent conversions.
